// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX pipeline stage: control bundle layout,
// writeback-select encodings and the canonical entry layout at default widths.
package pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int ALU_CTRL_W = 5;

    // Writeback source select carried in ctrl.mem_to_reg
    localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC4 = 2'd2;
    localparam logic [1:0] MEM_TO_REG_IMM = 2'd3;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  alu_src;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
    } id_ex_ctrl_t;

    // Entry layout at the default widths; the top rebuilds the same layout
    // locally so that XLEN/REG_AW overrides remain possible.
    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc;
        logic [XLEN_DEF-1:0]   rd1;
        logic [XLEN_DEF-1:0]   rd2;
        logic [XLEN_DEF-1:0]   imm;
        logic [XLEN_DEF-1:0]   btarget;
        logic [REG_AW_DEF-1:0] rs1;
        logic [REG_AW_DEF-1:0] rs2;
        logic [REG_AW_DEF-1:0] rd;
        id_ex_ctrl_t           ctrl;
    } id_ex_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry elastic register (main + skid) with flush.
// in_ready is a pure register output so the downstream ready never
// combinationally reaches the upstream ready.
module pipe_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic m_valid;
    logic s_valid;
    T     m_data;
    T     s_data;

    logic accept;
    logic consume;
    logic m_load;

    // Skid entry is only occupied while main is stalled, so refusing new
    // input whenever it is full is enough to prevent overflow.
    assign in_ready  = ~s_valid;
    assign accept    = in_valid & in_ready;
    assign consume   = m_valid & out_ready;
    assign m_load    = ~m_valid | consume;

    assign out_valid = m_valid;
    assign out_data  = m_data;

    // Occupancy flags: main refills from skid first to keep FIFO order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_load) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
        end
    end

    // Payload registers; contents of empty entries are simply left stale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data <= '0;
            s_data <= '0;
        end else if (!flush) begin
            if (m_load) begin
                if (s_valid) begin
                    m_data <= s_data;
                end else if (accept) begin
                    m_data <= in_data;
                end
            end else if (accept) begin
                s_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipeline_id_ex_elastic.sv
// ID->EX pipeline stage: elastic two-entry register carrying decode results
// to execute, with the branch target precomputed on capture and the control
// bundle forced to zero whenever no valid instruction is presented.
module pipeline_id_ex_elastic
    import pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,     // asynchronous, active-low
    input  logic              flush,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  id_ex_ctrl_t       id_ctrl,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_branch_target,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output id_ex_ctrl_t       ex_ctrl
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   btarget;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        id_ex_ctrl_t       ctrl;
    } entry_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

    entry_t in_entry;
    entry_t out_entry;

    logic [CTRL_W-1:0] ctrl_raw;
    logic [CTRL_W-1:0] ctrl_gated;

    // Pack the decode bundle; branch target wraps modulo 2^XLEN
    always_comb begin
        in_entry         = '0;
        in_entry.pc      = id_pc;
        in_entry.rd1     = id_rd1;
        in_entry.rd2     = id_rd2;
        in_entry.imm     = id_imm;
        in_entry.btarget = id_pc + id_imm;
        in_entry.rs1     = id_rs1;
        in_entry.rs2     = id_rs2;
        in_entry.rd      = id_rd;
        in_entry.ctrl    = id_ctrl;
    end

    pipe_skid_buf #(
        .T (entry_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (id_valid),
        .in_ready  (id_ready),
        .in_data   (in_entry),
        .out_valid (ex_valid),
        .out_ready (ex_ready),
        .out_data  (out_entry)
    );

    assign ex_pc            = out_entry.pc;
    assign ex_rd1           = out_entry.rd1;
    assign ex_rd2           = out_entry.rd2;
    assign ex_imm           = out_entry.imm;
    assign ex_branch_target = out_entry.btarget;
    assign ex_rs1           = out_entry.rs1;
    assign ex_rs2           = out_entry.rs2;
    assign ex_rd            = out_entry.rd;

    // Bubbles must never write the register file or memory, so every
    // control bit is qualified by ex_valid.
    assign ctrl_raw = out_entry.ctrl;

    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
        assign ctrl_gated[gi] = ctrl_raw[gi] & ex_valid;
    end

    assign ex_ctrl = id_ex_ctrl_t'(ctrl_gated);

endmodule

// File: tb/tb_pipeline_id_ex_elastic.sv
// Bench for pipeline_id_ex_elastic: directed scenarios followed by random
// traffic, with a FIFO reference of accepted instructions checked by a monitor.
module tb_pipeline_id_ex_elastic;
    import pipe_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] btarget;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        id_ex_ctrl_t ctrl;
    } tb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_pc = '0;
    logic [31:0] id_rd1 = '0;
    logic [31:0] id_rd2 = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    id_ex_ctrl_t id_ctrl = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [31:0] ex_pc;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [31:0] ex_branch_target;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    id_ex_ctrl_t ex_ctrl;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference: instructions held by the stage, oldest first
    tb_entry_t exp_q[$];
    tb_entry_t pend_entry;
    logic      push_pend  = 1'b0;
    logic      flush_pend = 1'b0;

    always #5 clk = ~clk;

    pipeline_id_ex_elastic #(.XLEN(32), .REG_AW(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_pc            (id_pc),
        .id_rd1           (id_rd1),
        .id_rd2           (id_rd2),
        .id_imm           (id_imm),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .id_ctrl          (id_ctrl),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_rd1           (ex_rd1),
        .ex_rd2           (ex_rd2),
        .ex_imm           (ex_imm),
        .ex_branch_target (ex_branch_target),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .ex_ctrl          (ex_ctrl)
    );

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic rdy, input logic fl);
        tb_entry_t   e;
        logic [9:0]  cbits;
        @(posedge clk);
        #1;
        if (flush_pend) begin
            exp_q.delete();
            flush_pend = 1'b0;
        end
        if (push_pend) begin
            exp_q.push_back(pend_entry);
            push_pend = 1'b0;
        end
        if (rst) check_bit("id_ready", id_ready, exp_q.size() < 2);
        cbits     = 10'($urandom);
        e.pc      = pc;
        e.imm     = imm;
        e.rd1     = $urandom;
        e.rd2     = $urandom;
        e.rs1     = 5'($urandom_range(31));
        e.rs2     = 5'($urandom_range(31));
        e.rd      = 5'($urandom_range(31));
        e.ctrl    = id_ex_ctrl_t'(cbits);
        e.btarget = pc + imm;
        id_valid  = v;
        id_pc     = e.pc;
        id_imm    = e.imm;
        id_rd1    = e.rd1;
        id_rd2    = e.rd2;
        id_rs1    = e.rs1;
        id_rs2    = e.rs2;
        id_rd     = e.rd;
        id_ctrl   = e.ctrl;
        ex_ready  = rdy;
        flush     = fl;
        if (rst && v && id_ready && !fl) begin
            pend_entry = e;
            push_pend  = 1'b1;
        end
        if (fl) flush_pend = 1'b1;
    endtask

    // Monitor: sample mid-cycle, pop the oldest expected entry on each consume
    always @(negedge clk) begin
        tb_entry_t got;
        tb_entry_t want;
        if (rst) begin
            checks++;
            if (ex_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL ex_valid: got %0b expected %0b", ex_valid, exp_q.size() != 0);
            end
            if (!ex_valid) begin
                checks++;
                if (ex_ctrl !== '0) begin
                    errors++;
                    $display("FAIL bubble_ctrl: got %h expected 0", ex_ctrl);
                end
            end
            if (ex_valid && ex_ready) begin
                got.pc      = ex_pc;
                got.rd1     = ex_rd1;
                got.rd2     = ex_rd2;
                got.imm     = ex_imm;
                got.btarget = ex_branch_target;
                got.rs1     = ex_rs1;
                got.rs2     = ex_rs2;
                got.rd      = ex_rd;
                got.ctrl    = ex_ctrl;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got pc=%h btarget=%h expected no entry",
                             got.pc, got.btarget);
                end else begin
                    want = exp_q.pop_front();
                    txn++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL ex_entry: got pc=%h rd1=%h rd2=%h imm=%h bt=%h rs=%0d/%0d rd=%0d ctrl=%h expected pc=%h rd1=%h rd2=%h imm=%h bt=%h rs=%0d/%0d rd=%0d ctrl=%h",
                                 got.pc, got.rd1, got.rd2, got.imm, got.btarget, got.rs1, got.rs2, got.rd, got.ctrl,
                                 want.pc, want.rd1, want.rd2, want.imm, want.btarget, want.rs1, want.rs2, want.rd, want.ctrl);
                    end else begin
                        $display("txn %0d: pc=%h btarget=%h rd=%0d ctrl=%h", txn, got.pc, got.btarget, got.rd, got.ctrl);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held with decode already offering an instruction
        id_valid = 1'b1;
        id_pc    = 32'h0000_0abc;
        id_ctrl  = id_ex_ctrl_t'(10'h3ff);
        ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_ex_valid", ex_valid, 1'b0);
        check_word("reset_ex_ctrl", 32'(ex_ctrl), 32'h0);
        check_bit("reset_id_ready", id_ready, 1'b1);
        id_valid = 1'b0;
        rst      = 1'b1;

        // Streaming at full rate
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100, 32'h20, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall three cycles, then drain
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i * 4), 32'h8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with both entries held and a new input offered
        for (int i = 0; i < 2; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h3f0, 32'h10, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while the held entry is consumed in the same cycle
        step(1'b1, 32'h400, 32'h4, 1'b1, 1'b0);
        step(1'b1, 32'h404, 32'h4, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Branch-target wraparound
        step(1'b1, 32'hffff_fff0, 32'h20, 1'b1, 1'b0);
        step(1'b1, 32'hffff_ffff, 32'h1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with both entries full
        for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(i * 4), 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h508, 32'h40, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rst_ex_valid", ex_valid, 1'b0);
        check_word("async_rst_ex_pc", ex_pc, 32'h0);
        check_word("async_rst_ex_btarget", ex_branch_target, 32'h0);
        check_word("async_rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        check_bit("async_rst_id_ready", id_ready, 1'b1);
        exp_q.delete();
        push_pend  = 1'b0;
        flush_pend = 1'b0;
        id_valid   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(i * 4), 32'h100, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        // Drain and confirm nothing was lost
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0 || push_pend) begin
            errors++;
            $display("FAIL drain_empty: got %0d entries outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
